// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver and scancode-to-key decoder:
// decoder states, prefix/status byte values and the key-table entry width.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_SKIP
  } dec_state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_OVR0   = 8'h00;
  localparam logic [7:0] SC_OVR1   = 8'hFF;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;

  // The Pause key emits E1 followed by seven more bytes that carry no key state.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int ENTRY_W = 9;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 serial receiver: synchronises kclk/kdat, shifts one bit per falling
// kclk edge, checks parity/stop and flushes stalled frames after a timeout.
module ps2_rx #(
  parameter int TOUT_W = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kclk,
  input  logic       kdat,
  output logic       sc_valid,
  output logic [7:0] sc_data,
  output logic       err
);

  logic [1:0]        kclk_sync;
  logic [1:0]        kdat_sync;
  logic              kclk_prev;
  logic [10:0]       shift;
  logic [TOUT_W-1:0] tout_cnt;

  logic fall;
  logic frame_done;
  logic frame_good;
  logic timeout;
  logic partial;

  assign fall       = kclk_prev & ~kclk_sync[1];
  // The start bit (0) enters at bit 10; once it reaches bit 0 all 11 bits are in.
  assign frame_done = ~shift[0];
  assign frame_good = shift[10] & (^shift[9:1]);
  assign timeout    = &tout_cnt;
  assign partial    = ~&shift;

  // NOTE: every register here uses non-blocking assignment so all flops
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      kclk_sync <= 2'b11;
      kdat_sync <= 2'b11;
      kclk_prev <= 1'b1;
      shift     <= '1;
      tout_cnt  <= '0;
      sc_valid  <= 1'b0;
      sc_data   <= '0;
      err       <= 1'b0;
    end else begin
      kclk_sync <= {kclk_sync[0], kclk};
      kdat_sync <= {kdat_sync[0], kdat};
      kclk_prev <= kclk_sync[1];
      sc_valid  <= 1'b0;
      err       <= 1'b0;

      if (fall)
        tout_cnt <= '0;
      else if (!timeout)
        tout_cnt <= tout_cnt + TOUT_W'(1);

      // A falling edge outranks the timeout so a bit landing in that cycle is kept.
      if (frame_done) begin
        shift    <= '1;
        sc_valid <= frame_good;
        err      <= ~frame_good;
        if (frame_good)
          sc_data <= shift[8:1];
      end else if (fall) begin
        shift <= {kdat_sync[1], shift[10:1]};
      end else if (timeout) begin
        shift <= '1;
        err   <= partial;
      end
    end
  end

endmodule

// File: rtl/ps2_keymap.sv
// PS/2 keyboard front end: decodes E0/F0/E1 prefixed scancodes from ps2_rx
// and maintains a held-key bitmap for the keys listed in KEYMAP.
module ps2_keymap
  import ps2_pkg::*;
#(
  parameter int                         NKEYS  = 16,
  parameter int                         TOUT_W = 12,
  parameter logic [ENTRY_W*NKEYS-1:0]   KEYMAP = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kclk,
  input  logic             kdat,
  output logic [NKEYS-1:0] keys,
  output logic             sc_valid,
  output logic [7:0]       sc_data,
  output logic             key_evt,
  output logic [5:0]       key_idx,
  output logic             key_down,
  output logic             err
);

  ps2_rx #(
    .TOUT_W (TOUT_W)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .kclk     (kclk),
    .kdat     (kdat),
    .sc_valid (sc_valid),
    .sc_data  (sc_data),
    .err      (err)
  );

  dec_state_e state, state_next;
  logic [2:0] skip_cnt, skip_next;
  logic       do_code;
  logic       do_clear;
  logic       code_ext;
  logic       code_rel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
    end
  end

  // NOTE: each output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    do_code    = 1'b0;
    do_clear   = 1'b0;
    code_ext   = 1'b0;
    code_rel   = 1'b0;

    if (err) begin
      state_next = ST_IDLE;
      skip_next  = '0;
    end else if (sc_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (sc_data == SC_EXT) begin
            state_next = ST_EXT;
          end else if (sc_data == SC_BRK) begin
            state_next = ST_BRK;
          end else if (sc_data == SC_PAUSE) begin
            state_next = ST_SKIP;
            skip_next  = PAUSE_SKIP;
          end else if (sc_data == SC_OVR0 || sc_data == SC_OVR1) begin
            do_clear = 1'b1;
          end else if (sc_data != SC_BAT && sc_data != SC_ACK &&
                       sc_data != SC_RESEND) begin
            do_code = 1'b1;
          end
        end
        ST_EXT: begin
          if (sc_data == SC_BRK) begin
            state_next = ST_EXTBRK;
          end else begin
            state_next = ST_IDLE;
            do_code    = 1'b1;
            code_ext   = 1'b1;
          end
        end
        ST_BRK: begin
          state_next = ST_IDLE;
          do_code    = 1'b1;
          code_rel   = 1'b1;
        end
        ST_EXTBRK: begin
          state_next = ST_IDLE;
          do_code    = 1'b1;
          code_ext   = 1'b1;
          code_rel   = 1'b1;
        end
        ST_SKIP: begin
          if (skip_cnt <= 3'd1) begin
            state_next = ST_IDLE;
            skip_next  = '0;
          end else begin
            skip_next = skip_cnt - 3'd1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          skip_next  = '0;
        end
      endcase
    end
  end

  logic [NKEYS-1:0] match;
  logic             hit;
  logic [5:0]       hit_idx;
  logic             hit_state;

  // Descending scan so the lowest matching index is the one left in hit_idx.
  always_comb begin
    logic [ENTRY_W-1:0] entry;
    match     = '0;
    hit       = 1'b0;
    hit_idx   = '0;
    hit_state = 1'b0;
    entry     = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      entry = KEYMAP[i*ENTRY_W +: ENTRY_W];
      if (entry != '0 && entry == {code_ext, sc_data}) begin
        match[i]  = 1'b1;
        hit       = 1'b1;
        hit_idx   = 6'(i);
        hit_state = keys[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      keys     <= '0;
      key_evt  <= 1'b0;
      key_idx  <= '0;
      key_down <= 1'b0;
    end else begin
      key_evt <= 1'b0;
      if (do_clear) begin
        keys <= '0;
      end else if (do_code) begin
        keys <= code_rel ? (keys & ~match) : (keys | match);
        // Typematic repeats re-send the make code; only a real change is reported.
        if (hit && hit_state == code_rel) begin
          key_evt  <= 1'b1;
          key_idx  <= hit_idx;
          key_down <= ~code_rel;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keymap.sv
// Directed bench for ps2_keymap: a table of scancode frames with expected
// strobes and key bitmap, plus timeout and mid-frame reset sequences.
module tb_ps2_keymap;

  localparam int NKEYS  = 16;
  localparam int TOUT_W = 8;
  localparam logic [NKEYS*9-1:0] MAP =
      ((NKEYS*9)'(9'h01C) << 0)  |
      ((NKEYS*9)'(9'h175) << 27) |
      ((NKEYS*9)'(9'h014) << 45) |
      ((NKEYS*9)'(9'h077) << 54) |
      ((NKEYS*9)'(9'h01C) << 63);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             kclk = 1'b1;
  logic             kdat = 1'b1;
  logic [NKEYS-1:0] keys;
  logic             sc_valid;
  logic [7:0]       sc_data;
  logic             key_evt;
  logic [5:0]       key_idx;
  logic             key_down;
  logic             err;

  ps2_keymap #(
    .NKEYS  (NKEYS),
    .TOUT_W (TOUT_W),
    .KEYMAP (MAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .kclk     (kclk),
    .kdat     (kdat),
    .keys     (keys),
    .sc_valid (sc_valid),
    .sc_data  (sc_data),
    .key_evt  (key_evt),
    .key_idx  (key_idx),
    .key_down (key_down),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled on the falling clk edge away from output updates.
  int         cyc = 0;
  int         n_valid = 0;
  int         n_errs_seen = 0;
  int         n_evt = 0;
  int         valid_cyc = 0;
  int         evt_cyc = 0;
  logic [7:0] last_data = '0;
  logic [5:0] last_idx = '0;
  logic       last_down = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sc_valid) begin
      n_valid   = n_valid + 1;
      last_data = sc_data;
      valid_cyc = cyc;
    end
    if (err)
      n_errs_seen = n_errs_seen + 1;
    if (key_evt) begin
      n_evt     = n_evt + 1;
      last_idx  = key_idx;
      last_down = key_down;
      evt_cyc   = cyc;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    kdat = b;
    repeat (5) @(posedge clk);
    kclk = 1'b0;
    repeat (10) @(posedge clk);
    kclk = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad);
    logic par;
    par = (~^d) ^ bad;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] d, input bit bad);
    logic [10:0] f;
    f = make_frame(d, bad);
    for (int i = 0; i < 11; i++)
      send_bit(f[i]);
    kdat = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          bad;
    bit          exp_valid;
    bit          exp_err;
    int          exp_evt;
    logic [5:0]  exp_idx;
    bit          exp_down;
    logic [15:0] exp_keys;
  } vec_t;

  vec_t vecs[20];

  task automatic apply_vec(input int i);
    int v0, e0, k0;
    v0 = n_valid;
    e0 = n_errs_seen;
    k0 = n_evt;
    send_byte(vecs[i].data, vecs[i].bad);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check($sformatf("v%0d sc_valid count", i), 32'(n_valid - v0), 32'(vecs[i].exp_valid));
    check($sformatf("v%0d err count", i), 32'(n_errs_seen - e0), 32'(vecs[i].exp_err));
    check($sformatf("v%0d key_evt count", i), 32'(n_evt - k0), 32'(vecs[i].exp_evt));
    check($sformatf("v%0d keys", i), 32'(keys), 32'(vecs[i].exp_keys));
    if (vecs[i].exp_valid)
      check($sformatf("v%0d sc_data", i), 32'(last_data), 32'(vecs[i].data));
    if (vecs[i].exp_evt != 0) begin
      check($sformatf("v%0d key_idx", i), 32'(last_idx), 32'(vecs[i].exp_idx));
      check($sformatf("v%0d key_down", i), 32'(last_down), 32'(vecs[i].exp_down));
    end
  endtask

  initial begin
    int e0, v0, k0;
    logic [10:0] f;

    //          data   bad vld err evt idx  down keys
    vecs[0]  = '{8'h1C, 0, 1, 0, 1, 6'd0, 1, 16'h0081};
    vecs[1]  = '{8'h1C, 0, 1, 0, 0, 6'd0, 0, 16'h0081};
    vecs[2]  = '{8'hF0, 0, 1, 0, 0, 6'd0, 0, 16'h0081};
    vecs[3]  = '{8'h1C, 0, 1, 0, 1, 6'd0, 0, 16'h0000};
    vecs[4]  = '{8'hE0, 0, 1, 0, 0, 6'd0, 0, 16'h0000};
    vecs[5]  = '{8'h75, 0, 1, 0, 1, 6'd3, 1, 16'h0008};
    vecs[6]  = '{8'h75, 0, 1, 0, 0, 6'd0, 0, 16'h0008};
    vecs[7]  = '{8'h1C, 1, 0, 1, 0, 6'd0, 0, 16'h0008};
    vecs[8]  = '{8'hAA, 0, 1, 0, 0, 6'd0, 0, 16'h0008};
    vecs[9]  = '{8'h1C, 0, 1, 0, 1, 6'd0, 1, 16'h0089};
    vecs[10] = '{8'hE1, 0, 1, 0, 0, 6'd0, 0, 16'h0089};
    vecs[11] = '{8'h14, 0, 1, 0, 0, 6'd0, 0, 16'h0089};
    vecs[12] = '{8'h77, 0, 1, 0, 0, 6'd0, 0, 16'h0089};
    vecs[13] = '{8'hE1, 0, 1, 0, 0, 6'd0, 0, 16'h0089};
    vecs[14] = '{8'hF0, 0, 1, 0, 0, 6'd0, 0, 16'h0089};
    vecs[15] = '{8'h14, 0, 1, 0, 0, 6'd0, 0, 16'h0089};
    vecs[16] = '{8'hF0, 0, 1, 0, 0, 6'd0, 0, 16'h0089};
    vecs[17] = '{8'h77, 0, 1, 0, 0, 6'd0, 0, 16'h0089};
    vecs[18] = '{8'hFF, 0, 1, 0, 0, 6'd0, 0, 16'h0000};
    vecs[19] = '{8'h14, 0, 1, 0, 1, 6'd5, 1, 16'h0020};

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset keys", 32'(keys), 32'h0);
    check("reset sc_valid", 32'(sc_valid), 32'h0);
    check("reset sc_data", 32'(sc_data), 32'h0);
    check("reset key_evt", 32'(key_evt), 32'h0);
    check("reset key_idx", 32'(key_idx), 32'h0);
    check("reset key_down", 32'(key_down), 32'h0);
    check("reset err", 32'(err), 32'h0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    for (int i = 0; i <= 8; i++) begin
      apply_vec(i);
      if (i == 0)
        check("press lands one cycle after sc_valid", 32'(evt_cyc - valid_cyc), 32'd1);
    end

    // F0 accepted, then a frame stalls after 8 edges: timeout error drops the prefix.
    v0 = n_valid;
    send_byte(8'hF0, 0);
    repeat (10) @(posedge clk);
    check("timeout prefix F0 received", 32'(n_valid - v0), 32'd1);
    f = make_frame(8'hF0, 0);
    for (int i = 0; i < 8; i++)
      send_bit(f[i]);
    kdat = 1'b1;
    e0 = n_errs_seen;
    v0 = n_valid;
    repeat ((1 << TOUT_W) + 40) @(posedge clk);
    check("timeout err count", 32'(n_errs_seen - e0), 32'd1);
    check("timeout no sc_valid", 32'(n_valid - v0), 32'd0);

    for (int i = 9; i < 20; i++)
      apply_vec(i);

    // Reset while bit 5 of a frame is on the wire.
    f = make_frame(8'h55, 0);
    for (int i = 0; i < 6; i++)
      send_bit(f[i]);
    kdat = f[6];
    repeat (3) @(posedge clk);
    kclk = 1'b0;
    e0 = n_errs_seen;
    repeat (4) @(posedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    kclk = 1'b1;
    kdat = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midframe reset keys", 32'(keys), 32'h0);
    check("midframe reset sc_data", 32'(sc_data), 32'h0);
    check("midframe reset key_idx", 32'(key_idx), 32'h0);
    check("midframe reset key_down", 32'(key_down), 32'h0);
    check("midframe reset strobes", 32'({sc_valid, key_evt, err}), 32'h0);
    reset = 1'b0;
    repeat ((1 << TOUT_W) + 40) @(posedge clk);
    check("midframe reset no err", 32'(n_errs_seen - e0), 32'd0);

    v0 = n_valid;
    k0 = n_evt;
    send_byte(8'h77, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("post-reset sc_valid count", 32'(n_valid - v0), 32'd1);
    check("post-reset sc_data", 32'(last_data), 32'h77);
    check("post-reset key_evt count", 32'(n_evt - k0), 32'd1);
    check("post-reset key_idx", 32'(last_idx), 32'd6);
    check("post-reset key_down", 32'(last_down), 32'd1);
    check("post-reset keys", 32'(keys), 32'h0040);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_fail);
    $finish;
  end

endmodule
